// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default geometry and the
// Gray/binary conversion helpers used by both pointer domains.
package fifo_pkg;

    // Default FIFO geometry; every FIFO block derives its depth from this.
    localparam int FIFO_ADDR_WIDTH = 8;
    localparam int DEPTH           = 2 ** FIFO_ADDR_WIDTH;

    // Widest pointer the helpers support; callers pass their own width.
    localparam int CODE_MAX_W = 32;

    // Binary to reflected Gray. Bits above 'width' are cleared.
    function automatic logic [CODE_MAX_W-1:0] bin2gray(
        input logic [CODE_MAX_W-1:0] bin,
        input int                    width
    );
        logic [CODE_MAX_W-1:0] gray;
        gray = (bin >> 1) ^ bin;
        for (int i = 0; i < CODE_MAX_W; i++) begin
            if (i >= width) gray[i] = 1'b0;
        end
        return gray;
    endfunction

    // Reflected Gray to binary: each binary bit is the XOR of all Gray bits
    // at or above it. Bits above 'width' are cleared.
    function automatic logic [CODE_MAX_W-1:0] gray2bin(
        input logic [CODE_MAX_W-1:0] gray,
        input int                    width
    );
        logic [CODE_MAX_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < CODE_MAX_W; i++) begin
            if (i < width) bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the write-side and read-side pointer blocks.
module fifo_gray2bin #(
    parameter int width = 9
) (
    input  logic [width-1:0] gray,
    output logic [width-1:0] bin
);

    // Each binary bit is the parity of the Gray bits at and above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < width; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/status block of the dual-clock FIFO.
// Owns the binary and Gray write pointers, the RAM write address and the
// full flag, and adds a pessimistic fill level, an almost-full flag and a
// sticky overflow flag. The level and full flag only ever overstate the
// occupancy, because the read pointer seen here lags the real one by the
// synchroniser latency.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int addr_width   = FIFO_ADDR_WIDTH,
    parameter int afull_thresh = 2 ** addr_width - 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [addr_width:0]   wq2_rptr,
    input  logic                  wovf_clr,
    output logic [addr_width-1:0] waddr,
    output logic [addr_width:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [addr_width:0]   wlevel,
    output logic                  woverflow
);

    localparam int PW = addr_width + 1;

    logic          wen;
    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level_next;
    logic [PW-1:0] full_pattern;
    logic          full_next;
    logic          afull_next;

    // A write is accepted only while the registered full flag is low.
    assign wen   = winc & ~wfull;
    assign waddr = wbin[addr_width-1:0];

    // Natural modulo-2**(addr_width+1) wrap; the extra MSB distinguishes
    // full from empty.
    assign wbin_next  = wbin + {{addr_width{1'b0}}, wen};
    assign wgray_next = PW'(bin2gray(CODE_MAX_W'(wbin_next), PW));

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that means the top two bits inverted.
    assign full_pattern = {~wq2_rptr[addr_width -: 2], wq2_rptr[addr_width-2:0]};
    assign full_next    = (wgray_next == full_pattern);

    fifo_gray2bin #(
        .width (PW)
    ) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin_s)
    );

    // Level uses the post-write pointer so a write and a read-pointer
    // advance in the same cycle cancel out.
    assign level_next = wbin_next - rbin_s;
    assign afull_next = (int'({1'b0, level_next}) >= afull_thresh);

    // Pointer, full, level and almost-full registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= full_next;
            wlevel       <= level_next;
            walmost_full <= afull_next;
        end
    end

    // Sticky overflow: set by a write attempted while full; a clear in the
    // same cycle as a new set loses.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else begin
            woverflow <= (woverflow & ~wovf_clr) | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full with addr_width=2, afull_thresh=3.
// A counting model (accepted writes vs. decoded read position) is checked
// against the DUT on every falling edge; literal expectations pin the model.
module tb_fifo_wptr_full;

    localparam int AW  = 2;
    localparam int DEP = 4;
    localparam int AFT = 3;

    logic          wclk;
    logic          wrst_n;
    logic          winc;
    logic [AW:0]   wq2_rptr;
    logic          wovf_clr;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          woverflow;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    fifo_wptr_full #(
        .addr_width   (AW),
        .afull_thresh (AFT)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    initial wclk = 0;
    always #5 wclk = ~wclk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Position of a Gray value in the counting sequence.
    function automatic int g2i(input logic [AW:0] g);
        int r = 0;
        for (int i = 0; i < 8; i++) if (gray_tab[i] == int'(g)) r = i;
        return r;
    endfunction

    // ---- behavioural model: counts accepted writes, occupancy = writes - reads
    int   m_w, n_w;
    int   m_lvl, n_lvl;
    logic m_full, n_full, m_af, n_af, m_ovf, n_ovf;

    always_comb begin
        n_w   = m_w + ((winc && !m_full) ? 1 : 0);
        n_lvl = ((n_w - g2i(wq2_rptr)) % 8 + 8) % 8;
        n_full = (n_lvl == DEP);
        n_af   = (n_lvl >= AFT);
        n_ovf  = (m_ovf && !wovf_clr) || (winc && m_full);
    end

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            m_w <= 0; m_lvl <= 0; m_full <= 0; m_af <= 0; m_ovf <= 0;
        end else begin
            m_w <= n_w; m_lvl <= n_lvl; m_full <= n_full; m_af <= n_af; m_ovf <= n_ovf;
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge wclk) begin
        if (chk_en && wrst_n) begin
            check("cyc_wptr",  int'(wptr),  gray_tab[m_w % 8]);
            check("cyc_waddr", int'(waddr), m_w % DEP);
            check("cyc_wfull", int'(wfull), int'(m_full));
            check("cyc_afull", int'(walmost_full), int'(m_af));
            check("cyc_level", int'(wlevel), m_lvl);
            check("cyc_ovf",   int'(woverflow), int'(m_ovf));
        end
    end

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    int r_cnt;
    logic [AW:0] prev_ptr;
    bit saw_wrap;
    bit level_ok;

    initial begin
        wrst_n = 0; winc = 0; wq2_rptr = '0; wovf_clr = 0;
        step(); step();
        wrst_n = 1;
        chk_en = 1;
        step();

        // 1. asynchronous reset mid-stream after 3 writes
        winc = 1;
        repeat (3) step();
        winc = 0;
        check("pre_rst_wptr", int'(wptr), 2);
        #2 wrst_n = 0;
        #1;
        check("rst_wptr",  int'(wptr), 0);
        check("rst_level", int'(wlevel), 0);
        check("rst_full",  int'(wfull), 0);
        check("rst_afull", int'(walmost_full), 0);
        check("rst_ovf",   int'(woverflow), 0);
        check("rst_waddr", int'(waddr), 0);
        step(); step();
        wrst_n = 1;
        step();

        // 2. fill with read pointer at 0
        wq2_rptr = '0;
        winc = 1;
        check("fill_waddr0", int'(waddr), 0);
        step();
        check("fill_wptr1", int'(wptr), 1);
        check("fill_lvl1", int'(wlevel), 1);
        check("fill_waddr1", int'(waddr), 1);
        step();
        check("fill_wptr2", int'(wptr), 3);
        check("fill_lvl2", int'(wlevel), 2);
        check("fill_af2", int'(walmost_full), 0);
        check("fill_waddr2", int'(waddr), 2);
        step();
        check("fill_wptr3", int'(wptr), 2);
        check("fill_lvl3", int'(wlevel), 3);
        check("fill_af3", int'(walmost_full), 1);
        check("fill_full3", int'(wfull), 0);
        check("fill_waddr3", int'(waddr), 3);
        step();
        check("fill_wptr4", int'(wptr), 6);
        check("fill_lvl4", int'(wlevel), 4);
        check("fill_full4", int'(wfull), 1);

        // 3. overflow set / clear priority
        step();
        check("ovf_wptr", int'(wptr), 6);
        check("ovf_set", int'(woverflow), 1);
        wovf_clr = 1;
        step();
        check("ovf_set_wins", int'(woverflow), 1);
        check("ovf_wptr2", int'(wptr), 6);
        winc = 0;
        step();
        check("ovf_clr", int'(woverflow), 0);
        wovf_clr = 0;

        // 4. drain visibility
        wq2_rptr = 3'd1;
        check("drain_full_hold", int'(wfull), 1);
        step();
        check("drain_full_drop", int'(wfull), 0);
        check("drain_lvl3", int'(wlevel), 3);
        check("drain_af3", int'(walmost_full), 1);
        wq2_rptr = 3'd3;
        step();
        check("drain_lvl2", int'(wlevel), 2);
        check("drain_af2", int'(walmost_full), 0);

        // 6. simultaneous write and read-pointer advance at level 3
        winc = 1;
        step();
        check("sim_pre_lvl", int'(wlevel), 3);
        wq2_rptr = 3'd2;
        step();
        winc = 0;
        check("sim_lvl", int'(wlevel), 3);
        check("sim_full", int'(wfull), 0);
        check("sim_wptr", int'(wptr), gray_tab[6]);

        // 5. wrap-around with interleaved read-pointer advances
        r_cnt = 3;
        saw_wrap = 0;
        level_ok = 1;
        prev_ptr = wptr;
        for (int i = 0; i < 20; i++) begin
            winc = 1;
            if (i % 2 == 0) begin
                r_cnt = r_cnt + 1;
                wq2_rptr = 3'(gray_tab[r_cnt % 8]);
            end
            step();
            check("wrap_onebit", ($countones(prev_ptr ^ wptr) <= 1) ? 1 : 0, 1);
            if (prev_ptr == 3'd4 && wptr == 3'd0) saw_wrap = 1;
            if (wlevel > 3'(DEP)) level_ok = 0;
            prev_ptr = wptr;
        end
        winc = 0;
        check("wrap_seen", int'(saw_wrap), 1);
        check("wrap_level_bound", int'(level_ok), 1);
        step(); step();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
